// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Per-node writeback arbiter. Buffers force writeback records
//               from NUM_PIPES pipelines in small per-pipe FIFOs, picks one
//               head per cycle round-robin and presents it through a
//               registered valid/ready output stage. Also keeps a count of
//               forwarded records and an idle flag for the phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
  parameter int NUM_PIPES          = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int CELL_ID_WIDTH      = 3,
  parameter int PARTICLE_ID_WIDTH  = 7,
  parameter int FIFO_DEPTH         = 4,
  parameter int CNT_WIDTH          = 16,
  localparam int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  localparam int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH,
  localparam int SRC_WIDTH         = $clog2(NUM_PIPES)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PIPES-1:0]                wb_valid,
  input  logic [NUM_PIPES-1:0][WB_WIDTH-1:0]  wb_data,
  output logic [NUM_PIPES-1:0]                wb_ready,
  output logic                                out_valid,
  output logic [WB_WIDTH-1:0]                 out_data,
  output logic [SRC_WIDTH-1:0]                out_src,
  input  logic                                out_ready,
  input  logic                                clear_cnt,
  output logic [CNT_WIDTH-1:0]                fwd_count,
  output logic                                idle
);

  // FIFO pointers carry one extra wrap bit so full and empty are distinct.
  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_PTR_W  = c_ADDR_W + 1;
  // Wide enough to hold rr + offset (max 2*NUM_PIPES-2) before wrapping.
  localparam int c_SUM_W  = SRC_WIDTH + 1;
  localparam logic [SRC_WIDTH-1:0] c_LAST_PIPE = SRC_WIDTH'(NUM_PIPES - 1);
  localparam logic [SRC_WIDTH-1:0] c_SRC_ONE   = SRC_WIDTH'(1);
  localparam logic [c_SUM_W-1:0]   c_NUM_PIPES = c_SUM_W'(NUM_PIPES);

  // --------------------------------------------------------------------------
  // Per-pipe FIFO status and head records
  // --------------------------------------------------------------------------
  logic [NUM_PIPES-1:0] w_empty;
  logic [NUM_PIPES-1:0] w_full;
  logic [NUM_PIPES-1:0] w_push;
  logic [NUM_PIPES-1:0] w_pop;
  logic [WB_WIDTH-1:0]  w_head [NUM_PIPES];

  // Ready looks only at stored occupancy; a same-cycle pop never frees a slot
  // early, so there is no combinational path from out_ready to wb_ready.
  assign wb_ready = ~w_full;
  assign w_push   = wb_valid & ~w_full;

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_fifo
    logic [WB_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    // Pointer next-state: advance on accepted push / arbiter pop.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_push[p]) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      if (w_pop[p])  rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end

    // Pointer registers; reset empties the FIFO and drops its contents.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
      if (w_push[p]) mem_q[wr_ptr_q[c_ADDR_W-1:0]] <= wb_data[p];
    end

    assign w_empty[p] = (wr_ptr_q == rd_ptr_q);
    assign w_full[p]  = (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]) &&
                        (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]);
    // Head is read from storage only, so a record is never bypassed
    // straight from wb_data to the output in the cycle it is pushed.
    assign w_head[p]  = mem_q[rd_ptr_q[c_ADDR_W-1:0]];
  end

  // --------------------------------------------------------------------------
  // Round-robin selection
  // --------------------------------------------------------------------------
  logic [SRC_WIDTH-1:0] rr_q, rr_d;
  logic                 w_any;
  logic [SRC_WIDTH-1:0] w_win;
  logic                 w_load;

  // Scan non-empty FIFOs starting at the rr pointer, wrapping to pipe 0.
  always_comb begin
    logic [c_SUM_W-1:0] sum;
    w_any = 1'b0;
    w_win = '0;
    sum   = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      sum = {1'b0, rr_q} + c_SUM_W'(i);
      if (sum >= c_NUM_PIPES) sum = sum - c_NUM_PIPES;
      if (!w_any && !w_empty[sum[SRC_WIDTH-1:0]]) begin
        w_any = 1'b1;
        w_win = sum[SRC_WIDTH-1:0];
      end
    end
  end

  // The output stage can take a new record when empty or being drained.
  assign w_load = (!out_valid || out_ready) && w_any;

  // Pop the winner on load and move the rr pointer just past it.
  always_comb begin
    w_pop = '0;
    rr_d  = rr_q;
    if (w_load) begin
      w_pop[w_win] = 1'b1;
      rr_d         = (w_win == c_LAST_PIPE) ? '0 : w_win + c_SRC_ONE;
    end
  end

  // rr pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  // --------------------------------------------------------------------------
  // Output register stage
  // --------------------------------------------------------------------------
  logic                 out_valid_q, out_valid_d;
  logic [WB_WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SRC_WIDTH-1:0] out_src_q,   out_src_d;

  // Load a new winner, hold while stalled, drop valid once drained with
  // nothing left to send (data keeps its last value).
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      out_data_d  = w_head[w_win];
      out_src_d   = w_win;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  // --------------------------------------------------------------------------
  // Forwarded-record counter and idle flag
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] fwd_count_q, fwd_count_d;

  // Clear wins over a coincident transfer; the counter wraps naturally.
  always_comb begin
    fwd_count_d = fwd_count_q;
    if (clear_cnt)                      fwd_count_d = '0;
    else if (out_valid_q && out_ready)  fwd_count_d = fwd_count_q + CNT_WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) fwd_count_q <= '0;
    else        fwd_count_q <= fwd_count_d;
  end

  assign fwd_count = fwd_count_q;
  // Purely a function of registered state, so it never glitches on inputs.
  assign idle      = (&w_empty) && !out_valid_q;

endmodule
`default_nettype wire
